// File: rtl/pulse_gen_pkg.sv
// pulse_gen shared types: channel state encoding and mode encoding.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: trigger, programmable delay, programmable length,
// one-shot or periodic, optional retrigger.
module pulse_chan
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RETRIG = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             trig,
  input  logic             abort,
  input  logic             rep,
  input  logic [WIDTH-1:0] dly,
  input  logic [WIDTH-1:0] len,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic [WIDTH-1:0] l_q, l_n;
  logic             rep_q, rep_n;
  logic             done_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      d_q   <= '0;
      l_q   <= '0;
      rep_q <= MODE_ONESHOT;
      pulse <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d_q   <= d_n;
      l_q   <= l_n;
      rep_q <= rep_n;
      pulse <= (state_n == ST_ACTIVE);
      busy  <= (state_n != ST_IDLE);
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d_q;
    l_n     = l_q;
    rep_n   = rep_q;
    done_n  = 1'b0;
    case (state)
      ST_DELAY: begin
        if (cnt == d_q) begin
          if (l_q == '0) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            state_n = ST_ACTIVE;
            cnt_n   = WIDTH'(1);
          end
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end
      ST_ACTIVE: begin
        if (cnt == l_q) begin
          if (rep_q == MODE_PERIODIC) begin
            // Re-entry counts the falling edge as the first low cycle
            state_n = (d_q == '0) ? ST_ACTIVE : ST_DELAY;
            cnt_n   = WIDTH'(1);
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end
      default: ;
    endcase
    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      done_n  = 1'b0;
    end else if (trig && (RETRIG != 0 || state_n == ST_IDLE)) begin
      state_n = ST_DELAY;
      cnt_n   = '0;
      d_n     = dly;
      l_n     = len;
      rep_n   = (len == '0) ? MODE_ONESHOT : rep;
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel programmable pulse generator: one pulse_chan per channel
// with per-channel slicing of the packed delay/length buses.
module pulse_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int RETRIG   = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       rep,
  input  logic [CHANNELS*WIDTH-1:0] dly,
  input  logic [CHANNELS*WIDTH-1:0] len,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_chan #(
      .WIDTH  (WIDTH),
      .RETRIG (RETRIG)
    ) u_chan (
      .clk   (clk),
      .rstn  (rstn),
      .trig  (trig[i]),
      .abort (abort[i]),
      .rep   (rep[i]),
      .dly   (dly[i*WIDTH +: WIDTH]),
      .len   (len[i*WIDTH +: WIDTH]),
      .pulse (pulse[i]),
      .busy  (busy[i]),
      .done  (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: stimulus and expected-output scoreboards,
// RETRIG=0 and RETRIG=1 instances driven in lockstep.
module tb_pulse_gen;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CH-1:0] trig, abort, rep;
  logic [CH*W-1:0] dly, len;
  logic [CH-1:0] pulse0, busy0, done0;
  logic [CH-1:0] pulse1, busy1, done1;

  pulse_gen #(.CHANNELS(CH), .WIDTH(W), .RETRIG(0)) dut0 (
    .clk(clk), .rstn(rstn), .trig(trig), .abort(abort), .rep(rep),
    .dly(dly), .len(len), .pulse(pulse0), .busy(busy0), .done(done0)
  );

  pulse_gen #(.CHANNELS(CH), .WIDTH(W), .RETRIG(1)) dut1 (
    .clk(clk), .rstn(rstn), .trig(trig), .abort(abort), .rep(rep),
    .dly(dly), .len(len), .pulse(pulse1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] t;
    logic [CH-1:0] a;
    logic          chg;
  } stim_t;

  typedef struct packed {
    logic [CH-1:0] p;
    logic [CH-1:0] b;
    logic [CH-1:0] d;
  } exp_t;

  stim_t sq[$];
  exp_t  eq0[$];
  exp_t  eq1[$];
  int    checks = 0;
  int    errors = 0;

  // {pulse,busy,done} k cycles after an accepted one-shot trigger
  function automatic logic [2:0] os(int d, int l, int k);
    logic [2:0] v;
    v = '0;
    if (k >= 0) begin
      v[2] = (l > 0) && (k >= d + 1) && (k <= d + l);
      v[1] = (k <= d + l);
      v[0] = (k == d + l + 1);
    end
    return v;
  endfunction

  function automatic logic [2:0] per(int d, int l, int k, int ab);
    logic [2:0] v;
    v = '0;
    if (k >= 0 && k < ab) begin
      v[1] = 1'b1;
      v[2] = (k >= 1) && (((k - 1) % (d + l)) >= d);
    end
    return v;
  endfunction

  function automatic exp_t put(exp_t e, int ch, logic [2:0] v);
    exp_t r;
    r = e;
    r.p[ch] = v[2];
    r.b[ch] = v[1];
    r.d[ch] = v[0];
    return r;
  endfunction

  task automatic cfg(input int ch, input int d, input int l, input logic r);
    dly[ch*W +: W] = W'(d);
    len[ch*W +: W] = W'(l);
    rep[ch] = r;
  endtask

  task automatic push(input logic [CH-1:0] t, input logic [CH-1:0] a,
                      input logic chg, input exp_t e0, input exp_t e1);
    stim_t s;
    s.t = t;
    s.a = a;
    s.chg = chg;
    sq.push_back(s);
    eq0.push_back(e0);
    eq1.push_back(e1);
  endtask

  task automatic run(input string nm);
    int    k;
    stim_t s;
    exp_t  e0, e1;
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      trig = s.t;
      abort = s.a;
      if (s.chg) begin
        dly = ~dly;
        len = len ^ {CH{8'h5a}};
        rep = ~rep;
      end
      @(posedge clk);
      #1;
      trig = '0;
      abort = '0;
      e0 = eq0.pop_front();
      e1 = eq1.pop_front();
      checks += 2;
      if ({pulse0, busy0, done0} !== e0) begin
        errors++;
        $display("FAIL %s retrig0 k=%0d p/b/d got %b/%b/%b want %b/%b/%b",
                 nm, k, pulse0, busy0, done0, e0.p, e0.b, e0.d);
      end
      if ({pulse1, busy1, done1} !== e1) begin
        errors++;
        $display("FAIL %s retrig1 k=%0d p/b/d got %b/%b/%b want %b/%b/%b",
                 nm, k, pulse1, busy1, done1, e1.p, e1.b, e1.d);
      end
      k++;
    end
  endtask

  task automatic zero_check(input string nm);
    checks += 2;
    if ({pulse0, busy0, done0} !== '0) begin
      errors++;
      $display("FAIL %s retrig0 p/b/d got %b/%b/%b want all 0",
               nm, pulse0, busy0, done0);
    end
    if ({pulse1, busy1, done1} !== '0) begin
      errors++;
      $display("FAIL %s retrig1 p/b/d got %b/%b/%b want all 0",
               nm, pulse1, busy1, done1);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    trig = '0;
    abort = '0;
    rep = '0;
    dly = '0;
    len = '0;
    #12;
    zero_check("reset");
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) push('0, '0, 1'b0, '0, '0);
    run("idle");
  endtask

  task automatic test_oneshot();
    exp_t e;
    cfg(0, 3, 2, 1'b0);
    for (int k = 0; k < 10; k++) begin
      e = put('0, 0, os(3, 2, k));
      push((k == 0) ? 4'b0001 : 4'b0000, '0, 1'b0, e, e);
    end
    run("oneshot");
  endtask

  task automatic test_edges();
    int   dd[3] = '{0, 2, 255};
    int   ll[3] = '{1, 0, 255};
    int   nn[3] = '{4, 6, 514};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      cfg(1, dd[i], ll[i], 1'b0);
      for (int k = 0; k < nn[i]; k++) begin
        e = put('0, 1, os(dd[i], ll[i], k));
        push((k == 0) ? 4'b0010 : 4'b0000, '0, 1'b0, e, e);
      end
      run($sformatf("edge_d%0d_l%0d", dd[i], ll[i]));
    end
  endtask

  task automatic test_periodic();
    exp_t e;
    cfg(2, 1, 2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      e = put('0, 2, per(1, 2, k, 6));
      push((k == 0) ? 4'b0100 : 4'b0000,
           (k == 6) ? 4'b0100 : 4'b0000, 1'b0, e, e);
    end
    run("periodic");
    cfg(2, 0, 1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      e = put('0, 2, per(0, 1, k, 5));
      push((k == 0) ? 4'b0100 : 4'b0000,
           (k == 5) ? 4'b0100 : 4'b0000, 1'b0, e, e);
    end
    run("periodic_d0");
    cfg(2, 0, 0, 1'b0);
  endtask

  task automatic test_retrig();
    exp_t e0, e1;
    cfg(3, 4, 4, 1'b0);
    for (int k = 0; k < 17; k++) begin
      e0 = put('0, 3, os(4, 4, k));
      e1 = put('0, 3, (k < 6) ? os(4, 4, k) : os(4, 4, k - 6));
      push((k == 0 || k == 6) ? 4'b1000 : 4'b0000, '0, 1'b0, e0, e1);
    end
    run("retrig");
    for (int k = 0; k < 10; k++) begin
      e0 = put('0, 3, (k < 6) ? os(4, 4, k) : 3'b000);
      push((k == 0 || k == 6) ? 4'b1000 : 4'b0000,
           (k == 6) ? 4'b1000 : 4'b0000, 1'b0, e0, e0);
    end
    run("trig_abort");
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [2:0] v;
    cfg(0, 1, 1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      v = (k < 3) ? os(1, 1, k) : (os(1, 1, k - 3) | ((k == 3) ? 3'b001 : 3'b000));
      e = put('0, 0, v);
      push((k == 0 || k == 3) ? 4'b0001 : 4'b0000, '0, 1'b0, e, e);
    end
    run("back_to_back");
  endtask

  task automatic test_concurrent();
    int   dd[4] = '{2, 0, 5, 1};
    int   ll[4] = '{3, 4, 1, 0};
    exp_t e;
    for (int c = 0; c < CH; c++) cfg(c, dd[c], ll[c], 1'b0);
    for (int k = 0; k < 10; k++) begin
      e = '0;
      for (int c = 0; c < CH; c++) e = put(e, c, os(dd[c], ll[c], k));
      push((k == 0) ? 4'b1111 : 4'b0000, '0, (k == 1), e, e);
    end
    run("concurrent");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int c = 0; c < CH; c++) cfg(c, 1, 10, 1'b0);
    for (int k = 0; k < 6; k++) begin
      e = '0;
      for (int c = 0; c < CH; c++) e = put(e, c, os(1, 10, k));
      push((k == 0) ? 4'b1111 : 4'b0000, '0, 1'b0, e, e);
    end
    run("pre_reset");
    #1 rstn = 1'b0;
    #1 zero_check("reset_mid");
    #1 rstn = 1'b1;
    for (int k = 0; k < 5; k++) push('0, '0, 1'b0, '0, '0);
    run("post_reset");
    cfg(0, 0, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e = put('0, 0, os(0, 1, k));
      push((k == 0) ? 4'b0001 : 4'b0000, '0, 1'b0, e, e);
    end
    run("recover");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_edges();
    test_periodic();
    test_retrig();
    test_back_to_back();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
